dm_responder: RTL
=================

Name: dm_responder

Overview:
- Data-memory responder on the M-stage data-memory interface of the 5-stage pipelined CPU.
- Accepts byte-addressed, lane-positioned store data with a write length code. Returns the full aligned word on a combinational read path.
- Commits stores synchronously with byte-lane merging.
- Tracks committed-write count and latches the first illegal access (misaligned, out of range, or reserved length) with its PC.

Parameters:
- ADDR_WIDTH, 10, word-address bits; capacity is 2^ADDR_WIDTH words (default 4 KB).
- BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- DMAdr  input  32  byte address of the access.
- DMcurWE  input  1  store request this cycle.
- DMWLen  input  2  store length: 00 word, 01 halfword, 10 byte, 11 reserved.
- DMDataW  input  32  store data, already shifted into its byte lanes by the requester.
- DMcurPC  input  32  PC of the instruction in M; used for error capture and trace.
- DMDataR  output  32  full word at the word-aligned address; the requester extracts bytes/halves.
- err  output  1  sticky illegal-access flag.
- err_pc  output  32  DMcurPC of the first illegal store.
- err_adr  output  32  DMAdr of the first illegal store.
- wr_count  output  32  number of committed stores.

Behaviour:
- Reset (synchronous, active-high): all memory words, err, err_pc, err_adr and wr_count go to 0 on the clock edge where reset=1. No write commits in that cycle, even with DMcurWE=1.
- Read is combinational, zero latency.
  - off = DMAdr - BASE.
  - In range means off < 4*2^ADDR_WIDTH.
  - When in range, DMDataR = mem[off[ADDR_WIDTH+1:2]]; otherwise DMDataR = 0.
  - DMAdr[1:0] is ignored on reads.
- Read-during-write to the same word returns the old contents. The new value is visible the cycle after the edge.
- Byte enables, from DMWLen and DMAdr[1:0]:
  - word: 1111.
  - halfword: 0011 when adr[1]=0, 1100 when adr[1]=1.
  - byte: one-hot at adr[1:0]; lane 0 is bits [7:0].
- A store is legal when all of these hold:
  - DMcurWE=1;
  - in range;
  - DMWLen != 11;
  - word has adr[1:0]=00;
  - halfword has adr[0]=0.
- Legal store: at posedge, enabled lanes take DMDataW lanes and the other lanes keep their value. wr_count increments by 1 and wraps from 32'hFFFF_FFFF to 0.
- Illegal store (DMcurWE=1 but not legal):
  - memory and wr_count are unchanged;
  - err is set to 1;
  - err_pc and err_adr are captured only if err was 0 before the edge (first error wins);
  - err clears only on reset.
- DMcurWE=0 never changes state, whatever the other inputs are.
- Reads never raise err.
- State machine for the error monitor:
  - CLEAN → FAULTED on the first illegal store.
  - FAULTED is absorbing until reset.
  - err = (state == FAULTED).

Optional Feature:
- Macro DM_TRACE_EN.
- Defined: on every committed store, at the commit edge, print via $display the line "@<DMcurPC hex 8>: *<word-aligned DMAdr hex 8> <= <merged 32-bit word hex 8>". The printed value is the full post-merge word, not the raw DMDataW. Illegal stores print nothing.
- Not defined: no $display; function and timing are identical.

Test Plan:
- Reset then read: reset=1 for 1 cycle, DMAdr=0x10 → DMDataR=0, err=0, wr_count=0.
- Word store then read: WE=1, WLen=00, Adr=0x10, DataW=0x12345678; next cycle WE=0 → DMDataR=0x12345678, wr_count=1. With DM_TRACE_EN, prints "*00000010 <= 12345678".
- Lane merge:
  - after the word store above, byte store Adr=0x13, DataW=0xAB000000 → 0xAB345678;
  - then halfword store Adr=0x10, DataW=0x0000CDEF → 0xAB34CDEF;
  - wr_count=3.
- Read-during-write: WE=1, Adr=0x20 (holding 0), DataW=0xFFFFFFFF → DMDataR=0 that cycle, 0xFFFFFFFF the next cycle.
- Illegal stores:
  - word at Adr=0x22 with PC=0x3008 → memory unchanged, err=1, err_pc=0x3008, err_adr=0x22;
  - then WLen=11 at Adr=0x30 with PC=0x300C → err_pc is still 0x3008.
- Out of range and reset mid-operation:
  - with defaults, store to Adr=0x1000 → err=1 and DMDataR=0;
  - assert reset in the same cycle as a legal store to 0x40 → mem[0x40]=0, err=0, wr_count=0 after the edge.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: zero-latency word read, byte-lane merged stores, commit
// counter and first-illegal-store capture. Define DM_TRACE_EN for a commit trace.
module dm_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DMAdr,
  input  logic        DMcurWE,
  input  logic [1:0]  DMWLen,
  input  logic [31:0] DMDataW,
  input  logic [31:0] DMcurPC,
  output logic [31:0] DMDataR,
  output logic        err,
  output logic [31:0] err_pc,
  output logic [31:0] err_adr,
  output logic [31:0] wr_count
);

  localparam int          DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;

  typedef enum logic {CLEAN, FAULTED} err_state_t;

  err_state_t            state, state_next;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic                  aligned;
  logic                  legal;
  logic                  illegal;
  logic [31:0]           merged;

  assign off      = DMAdr - BASE;
  assign in_range = {1'b0, off} < SPAN;
  assign idx      = off[ADDR_WIDTH+1:2];
  assign DMDataR  = in_range ? mem[idx] : 32'h0;

  always_comb begin
    be      = 4'b0000;
    aligned = 1'b0;
    case (DMWLen)
      2'b00: begin
        be      = 4'b1111;
        aligned = (DMAdr[1:0] == 2'b00);
      end
      2'b01: begin
        be      = DMAdr[1] ? 4'b1100 : 4'b0011;
        aligned = ~DMAdr[0];
      end
      2'b10: begin
        be      = 4'b0001 << DMAdr[1:0];
        aligned = 1'b1;
      end
      default: begin
        be      = 4'b0000;
        aligned = 1'b0;
      end
    endcase
  end

  assign legal   = DMcurWE & in_range & aligned;
  assign illegal = DMcurWE & ~legal;

  // The old word is the read-path value, so the merge also gives read-during-write old data.
  always_comb begin
    merged = DMDataR;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = DMDataW[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (legal) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wr_count <= 32'h0;
    else if (legal) wr_count <= wr_count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAN;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == CLEAN && illegal) state_next = FAULTED;
  end

  always_comb begin
    err = (state == FAULTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_pc  <= 32'h0;
      err_adr <= 32'h0;
    end else if (illegal && state == CLEAN) begin
      err_pc  <= DMcurPC;
      err_adr <= DMAdr;
    end
  end

`ifdef DM_TRACE_EN
  always @(posedge clk) begin
    if (!reset && legal)
      $display("@%08h: *%08h <= %08h", DMcurPC, {DMAdr[31:2], 2'b00}, merged);
  end
`endif

endmodule
